// File: rtl/down_counter_timer_if.sv
// -----------------------------------------------------------------------------
// down_counter_timer_if
//   Bundles the control and status signals of down_counter_timer.
//   Clock and reset are not part of the bundle.
//
//   Signals (direction as seen by the timer, i.e. the slave):
//     start   in   begin a countdown (used in IDLE only)
//     en      in   decrement enable (used in RUN only)
//     reload  in   auto-reload request (used in DONE only)
//     abort   in   cancel any countdown (used in every state)
//     initld  in   n-bit countdown start value
//     busy    out  high while counting (RUN)
//     done    out  high for the DONE cycle(s)
//     bo      out  borrow/zero flag, out == 0, combinational
//     out     out  n-bit registered count value
// -----------------------------------------------------------------------------
interface down_counter_timer_if #(
  parameter int n = 6
);
  logic         start;
  logic         en;
  logic         reload;
  logic         abort;
  logic [n-1:0] initld;
  logic         busy;
  logic         done;
  logic         bo;
  logic [n-1:0] out;

  // Controller side: drives requests, observes status.
  modport master (
    output start, en, reload, abort, initld,
    input  busy, done, bo, out
  );

  // Timer side.
  modport slave (
    input  start, en, reload, abort, initld,
    output busy, done, bo, out
  );
endinterface

// File: rtl/down_counter_timer.sv
// -----------------------------------------------------------------------------
// down_counter_timer
//   Loadable down-counter with start/busy/done sequencing. A start in IDLE
//   loads initld and counts down on each enabled cycle; reaching zero enters
//   DONE for one cycle (or reloads when reload is high). abort returns to IDLE
//   from any state without a done pulse.
//
//   Ports:
//     clk_i  in   system clock, all state changes on posedge
//     rst_i  in   synchronous active-high reset
//     bus    --   down_counter_timer_if.slave (start/en/reload/abort/initld
//                 in; busy/done/bo/out out)
// -----------------------------------------------------------------------------
module down_counter_timer #(
  parameter int n = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  down_counter_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [n-1:0] ONE = n'(1);

  state_e       state_q, state_d;
  logic [n-1:0] out_q, out_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;

    if (bus.abort) begin
      state_d = IDLE;
      out_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            out_d   = bus.initld;
            // A zero load has nothing to count and finishes immediately.
            state_d = (bus.initld != '0) ? RUN : DONE;
          end
        end

        RUN: begin
          if (bus.en) begin
            // out is never 0 in RUN, so the decrement cannot wrap.
            out_d = out_q - ONE;
            if (out_q == ONE) begin
              state_d = DONE;
            end
          end
        end

        DONE: begin
          if (bus.reload) begin
            out_d   = bus.initld;
            state_d = (bus.initld != '0) ? RUN : DONE;
          end else begin
            out_d   = '0;
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
          out_d   = '0;
        end
      endcase
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.bo   = (out_q == '0);
  assign bus.out  = out_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// -----------------------------------------------------------------------------
// tb_down_counter_timer
//   Directed stimulus for down_counter_timer (n = 6). Each stimulus step drives
//   the inputs for one clock edge and queues the status expected after that
//   edge; a monitor pops one entry per falling edge and compares it.
// -----------------------------------------------------------------------------
module tb_down_counter_timer;

  localparam int N = 6;

  typedef struct {
    logic         busy;
    logic         done;
    logic [N-1:0] out;
    string        name;
  } exp_t;

  logic clk;
  logic rst;

  int   total_checks;
  int   passed_checks;
  exp_t exp_q[$];
  bit   stim_done;

  down_counter_timer_if #(.n(N)) bus ();

  down_counter_timer #(.n(N)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    total_checks++;
    if (act === req) begin
      passed_checks++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // Drive inputs for one edge, then queue the status expected after it.
  task automatic step(input logic s, input logic e, input logic rl,
                      input logic ab, input logic r, input logic [N-1:0] ld,
                      input logic eb, input logic ed, input logic [N-1:0] eo,
                      input string nm);
    exp_t x;
    bus.start  = s;
    bus.en     = e;
    bus.reload = rl;
    bus.abort  = ab;
    bus.initld = ld;
    rst        = r;
    @(posedge clk);
    #1;
    x.busy = eb;
    x.done = ed;
    x.out  = eo;
    x.name = nm;
    exp_q.push_back(x);
  endtask

  // Monitor: compare one queued expectation per falling edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check({x.name, ".busy"}, 32'(bus.busy), 32'(x.busy));
        check({x.name, ".done"}, 32'(bus.done), 32'(x.done));
        check({x.name, ".out"},  32'(bus.out),  32'(x.out));
        check({x.name, ".bo"},   32'(bus.bo),   32'(x.out == '0));
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    stim_done  = 1'b0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.en     = 1'b0;
    bus.reload = 1'b0;
    bus.abort  = 1'b0;
    bus.initld = '0;

    //    s  e  rl ab r  ld      busy done out
    step(0, 0, 0, 0, 1, 6'd0,   0, 0, 6'd0, "reset");
    step(0, 0, 0, 0, 0, 6'd0,   0, 0, 6'd0, "idle");

    // Basic countdown from 5 with en held high.
    step(1, 1, 0, 0, 0, 6'd5,   1, 0, 6'd5, "basic_load");
    for (int k = 4; k >= 1; k--)
      step(0, 1, 0, 0, 0, 6'd5, 1, 0, N'(k), "basic_cnt");
    step(0, 1, 0, 0, 0, 6'd5,   0, 1, 6'd0, "basic_done");
    step(0, 1, 0, 0, 0, 6'd5,   0, 0, 6'd0, "basic_idle");

    // Stalls: en 1,0,1,0,1 -> 3,2,2,1,1,0.
    step(1, 0, 0, 0, 0, 6'd3,   1, 0, 6'd3, "stall_load");
    step(0, 1, 0, 0, 0, 6'd3,   1, 0, 6'd2, "stall_e1");
    step(0, 0, 0, 0, 0, 6'd3,   1, 0, 6'd2, "stall_e0a");
    step(0, 1, 0, 0, 0, 6'd3,   1, 0, 6'd1, "stall_e1b");
    step(0, 0, 0, 0, 0, 6'd3,   1, 0, 6'd1, "stall_e0b");
    step(0, 1, 0, 0, 0, 6'd3,   0, 1, 6'd0, "stall_done");
    step(0, 0, 0, 0, 0, 6'd3,   0, 0, 6'd0, "stall_idle");

    // en in IDLE is ignored.
    step(0, 1, 0, 0, 0, 6'd7,   0, 0, 6'd0, "idle_en");

    // Zero load: DONE right away, no busy.
    step(1, 1, 0, 0, 0, 6'd0,   0, 1, 6'd0, "zero_done");
    step(0, 1, 0, 0, 0, 6'd0,   0, 0, 6'd0, "zero_idle");

    // Zero load with reload of zero: stays in DONE.
    step(1, 0, 0, 0, 0, 6'd0,   0, 1, 6'd0, "zrl_done");
    step(0, 0, 1, 0, 0, 6'd0,   0, 1, 6'd0, "zrl_hold");
    step(0, 0, 0, 0, 0, 6'd0,   0, 0, 6'd0, "zrl_idle");

    // Max load 63: 63 enabled cycles, no wrap.
    step(1, 1, 0, 0, 0, 6'd63,  1, 0, 6'd63, "max_load");
    for (int k = 62; k >= 1; k--)
      step(0, 1, 0, 0, 0, 6'd63, 1, 0, N'(k), "max_cnt");
    step(0, 1, 0, 0, 0, 6'd63,  0, 1, 6'd0, "max_done");
    step(0, 1, 0, 0, 0, 6'd63,  0, 0, 6'd0, "max_idle");

    // Auto-reload with 2: 2,1,0,2,1,0 then drop reload.
    step(1, 1, 1, 0, 0, 6'd2,   1, 0, 6'd2, "arl_load");
    step(0, 1, 1, 0, 0, 6'd2,   1, 0, 6'd1, "arl_c1");
    step(0, 1, 1, 0, 0, 6'd2,   0, 1, 6'd0, "arl_done1");
    step(0, 1, 1, 0, 0, 6'd2,   1, 0, 6'd2, "arl_reload");
    step(0, 1, 0, 0, 0, 6'd2,   1, 0, 6'd1, "arl_c2");
    step(0, 1, 0, 0, 0, 6'd2,   0, 1, 6'd0, "arl_done2");
    step(0, 1, 0, 0, 0, 6'd2,   0, 0, 6'd0, "arl_idle");

    // Abort while out = 4.
    step(1, 1, 0, 0, 0, 6'd6,   1, 0, 6'd6, "abt_load");
    step(0, 1, 0, 0, 0, 6'd6,   1, 0, 6'd5, "abt_c5");
    step(0, 1, 0, 0, 0, 6'd6,   1, 0, 6'd4, "abt_c4");
    step(0, 1, 0, 1, 0, 6'd6,   0, 0, 6'd0, "abt_idle");
    step(0, 1, 0, 0, 0, 6'd6,   0, 0, 6'd0, "abt_nodone");

    // Reset while out = 2.
    step(1, 1, 0, 0, 0, 6'd4,   1, 0, 6'd4, "rst_load");
    step(0, 1, 0, 0, 0, 6'd4,   1, 0, 6'd3, "rst_c3");
    step(0, 1, 0, 0, 0, 6'd4,   1, 0, 6'd2, "rst_c2");
    step(0, 1, 0, 0, 1, 6'd4,   0, 0, 6'd0, "rst_idle");
    step(0, 1, 0, 0, 0, 6'd4,   0, 0, 6'd0, "rst_nodone");

    // Abort together with start in IDLE: no load.
    step(1, 1, 0, 1, 0, 6'd9,   0, 0, 6'd0, "abt_start");
    step(0, 0, 0, 0, 0, 6'd9,   0, 0, 6'd0, "abt_start2");

    // Abort in DONE beats reload.
    step(1, 0, 0, 0, 0, 6'd0,   0, 1, 6'd0, "abt_dn_done");
    step(0, 0, 1, 1, 0, 6'd5,   0, 0, 6'd0, "abt_dn_idle");

    // start during RUN with a different initld is ignored.
    step(1, 0, 0, 0, 0, 6'd4,   1, 0, 6'd4, "rs_load");
    step(1, 1, 0, 0, 0, 6'd20,  1, 0, 6'd3, "rs_c3");
    step(1, 0, 0, 0, 0, 6'd20,  1, 0, 6'd3, "rs_hold");
    step(1, 1, 0, 0, 0, 6'd20,  1, 0, 6'd2, "rs_c2");
    step(0, 1, 0, 0, 0, 6'd20,  1, 0, 6'd1, "rs_c1");
    step(0, 1, 0, 0, 0, 6'd20,  0, 1, 6'd0, "rs_done");
    step(0, 0, 0, 0, 0, 6'd20,  0, 0, 6'd0, "rs_idle");

    stim_done = 1'b1;
  end

  // Summary once stimulus is finished and the monitor has drained the queue.
  initial begin
    wait (stim_done);
    repeat (3) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
# down_counter_timer

Loadable down-counter with a start/busy/done handshake: counts down from a loaded value to zero and signals completion. It is the counterpart of the team's loadable up-counter, which counts up and raises carry-out at all-ones. This block counts toward zero, raises a borrow flag, and owns its own sequencing. Controllers use it for loop bounds and wait intervals where the consumer needs a "finished" event rather than a carry.

## Interface
- n, 6, count width in bits; legal range 2..16
- clk  input  1  system clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset, sampled on posedge clk
- start  input  1  begin a countdown; sampled only in IDLE
- en  input  1  decrement enable; sampled only in RUN
- reload  input  1  auto-reload mode; sampled only in DONE
- abort  input  1  cancel any countdown; sampled in every state
- initld  input  n  countdown start value; sampled on start and on reload
- busy  output  1  high while in RUN
- done  output  1  high for exactly the DONE cycle(s)
- bo  output  1  borrow/zero flag, combinational (out == 0)
- out  output  n  current count value, registered

## Operation
- States are IDLE, RUN and DONE.
  - busy = (state == RUN).
  - done = (state == DONE).
  - Both outputs are state decodes with no added logic.
- Reset (rst=1 at a posedge) has priority over all other inputs:
  - state goes to IDLE and out to 0.
  - Therefore busy=0, done=0, bo=1.
  - Reset mid-countdown discards the count and produces no done.
- abort (rst=0) has the next priority:
  - from any state, go to IDLE with out=0.
  - No done pulse is produced.
  - abort with start in IDLE: abort wins and the block stays IDLE.
- IDLE:
  - start=1 loads out<=initld.
  - Next state is RUN if initld≠0, else DONE.
  - Otherwise out holds.
  - en and reload are ignored.
- RUN:
  - en=1 and out>1: out<=out-1, stay in RUN.
  - en=1 and out==1: out<=0, go to DONE.
  - en=0: hold.
  - start is ignored. There is no restart while busy.
- DONE:
  - Held for one cycle unless reloading.
  - reload=0: go to IDLE, out stays 0.
  - reload=1: out<=initld; go to RUN if initld≠0, else stay in DONE (done stays high).
  - en and start are ignored in DONE.
- Arithmetic:
  - Decrement is n-bit modulo, but it is never applied at 0, so out never wraps to all-ones.
  - The all-ones initld value (2^n−1) is legal.

## Timing
- Start-to-done latency, with start sampled at edge E0, en held high and initld=N:
  - out=N after E0.
  - out=N−k after edge E0+k.
  - done is high after edge E0+N and lasts one cycle.
  - This gives N cycles of busy.
- N=0: done is high right after E0, with no busy cycle.
- Every en=0 cycle in RUN adds exactly one cycle of latency.
- Auto-reload with en held high gives a period of N+1 cycles between done pulses.
- Outputs:
  - busy, done and out are registered.
  - bo is combinational from out and is valid in the same cycle.
  - The environment may issue start in the cycle after the DONE→IDLE edge, so back-to-back runs have one idle cycle.

## Test plan
- Basic countdown:
  - Stimulus: rst, then start with initld=5, en=1 constant.
  - Required: out goes 5,4,3,2,1,0; busy high 5 cycles; done high for 1 cycle coinciding with out=0, bo=1; then IDLE.
- Stalls:
  - Stimulus: initld=3, en toggled 1,0,1,0,1.
  - Required: out goes 3,2,2,1,1,0; done arrives 5 cycles after start.
- Zero and max load:
  - initld=0: done asserts right after start, busy never asserts.
  - initld=63 (n=6): done after exactly 63 enabled cycles, with no wrap.
- Auto-reload:
  - Stimulus: initld=2, reload=1, en=1.
  - Required: done pulses every 3 cycles; out sequence 2,1,0,2,1,0.
  - Drop reload: the block returns to IDLE after the next done.
- Abort and reset mid-run:
  - abort while out=4: IDLE next cycle, out=0, no done.
  - rst while out=2: same result.
  - abort with start together in IDLE: no load.
- Ignored inputs:
  - start asserted during RUN with a different initld: count is unaffected.
  - en asserted in IDLE: out is unchanged.
